// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the instruction decoder.
// LOADER_CHECKSUM_EN adds the S_CSUM state (trailing XOR checksum byte).
package loader_pkg;

  localparam int          WORD_W       = 32;
  localparam int          BYTE_W       = 8;
  localparam int          LEN_BYTES    = 4;
  // Decoder raises core_end when it fetches this word.
  localparam logic [31:0] END_SENTINEL = 32'hffff_ff00;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_TERM,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Host byte link plus instruction memory write port of the program loader.
interface program_loader_if #(
  parameter int ADDR_W = 12
) ();
  import loader_pkg::*;

  logic                  rx_valid;
  logic [BYTE_W-1:0]     rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_W-1:0]     imem_addr;
  logic [WORD_W-1:0]     imem_wdata;

  // Loader side.
  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  // Host / memory side.
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs accepted bytes into a little-endian 32-bit word (first byte -> [7:0]).
// word is valid only together with word_valid, which fires on the 4th byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              clr,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [1:0]  idx_q;
  logic [23:0] sh_q;

  // The 4th byte completes the word combinationally so the FSM acts on it
  // at the same edge that accepts it.
  assign word       = {data, sh_q};
  assign word_valid = en && (idx_q == 2'(LEN_BYTES - 1));

  // Byte index and shift register; oldest byte drifts down to [7:0].
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      idx_q <= '0;
      sh_q  <= '0;
    end else if (en) begin
      idx_q <= idx_q + 2'd1;
      sh_q  <= {data, sh_q[23:8]};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Length-prefixed byte stream -> instruction memory loader.
// Writes N words at addresses 0..N-1, then END_SENTINEL at address N.
// LOADER_CHECKSUM_EN: a trailing XOR checksum byte over all prior bytes is
// checked before the sentinel is written.
import loader_pkg::*;

module program_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  program_loader_if.slave   bus,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  // Largest N that still leaves a slot for the sentinel.
  localparam logic [31:0] MAX_LEN = 32'((64'd1 << ADDR_W) - 64'd1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                rx_ready, accept, data_left;
  logic                asm_en, asm_clr, word_valid;
  logic [WORD_W-1:0]   word;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   csum_q;
`endif

  // Once all N words are written, the S_DATA cycle that hands off to
  // S_TERM must not swallow the byte that follows the program.
  assign data_left = (cnt_q != {1'b0, len_q});
  assign rx_ready  = (state_q == S_LEN) || ((state_q == S_DATA) && data_left)
`ifdef LOADER_CHECKSUM_EN
                     || (state_q == S_CSUM)
`endif
                     ;
  assign accept    = bus.rx_valid && rx_ready;
  assign asm_en    = accept && ((state_q == S_LEN) || (state_q == S_DATA));
  assign asm_clr   = (state_q != S_LEN) && (state_q != S_DATA);

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign load_done      = (state_q == S_DONE);
  assign load_err       = (state_q == S_ERR);
  assign words_loaded   = cnt_q;

  word_assembler u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .en         (asm_en),
    .clr        (asm_clr),
    .data       (bus.rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Next-state and next write-port values.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_LEN: begin
        if (word_valid) begin
          if (word > MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            len_d = word[ADDR_W-1:0];
            if (word == '0) begin
              state_d = S_TERM;
              we_d    = 1'b1;
              addr_d  = '0;
              wdata_d = END_SENTINEL;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (!data_left) begin
          state_d = S_TERM;
          we_d    = 1'b1;
          addr_d  = len_q;
          wdata_d = END_SENTINEL;
        end else if (word_valid) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = word;
          cnt_d   = cnt_q + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
          if (cnt_d == {1'b0, len_q}) state_d = S_CSUM;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (bus.rx_data == csum_q) begin
            state_d = S_TERM;
            we_d    = 1'b1;
            addr_d  = len_q;
            wdata_d = END_SENTINEL;
          end else begin
            state_d = S_ERR;
          end
        end
      end
`endif
      S_TERM:  state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_LEN;
    endcase
  end

  // State, counters and registered write port.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_LEN;
      len_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over length and data bytes; the checksum byte is excluded.
  always_ff @(posedge clk) begin
    if (!rstn)       csum_q <= '0;
    else if (asm_en) csum_q <= csum_q ^ bus.rx_data;
  end
`endif

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that fills instruction memory before the core runs. It accepts a length-prefixed, little-endian byte stream from the host link (UART receiver) and assembles it into 32-bit instruction words. Each word is written into instruction memory at consecutive word addresses. After the last word it writes the end-of-program sentinel 0xffffff00, which the instruction decoder detects to raise core_end. `load_done` releases the core from reset.

## Interface
- `ADDR_W`, default 12: instruction memory word-address width.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `rx_valid`  in  1  byte available from host link.
- `rx_data`  in  8  byte value.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction memory write strobe, one-cycle pulse per word.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  instruction word.
- `load_done`  out  1  program and sentinel written; stays high until reset.
- `load_err`  out  1  load aborted; stays high until reset.
- `words_loaded`  out  ADDR_W+1  count of program words written, sentinel excluded.

## Operation
- Byte accepted on a rising edge with `rx_valid && rx_ready`.
- `rx_ready` is 1 in states S_LEN, S_DATA and S_CSUM. It is 0 in all other states.
- Stream format:
  - 4 bytes: word count N, little-endian, 32-bit.
  - N×4 bytes: instruction words, little-endian, so the first byte goes to [7:0].
  - Optional checksum byte (see Configuration).
- States:
  - S_LEN: collect 4 length bytes.
    - N > 2^ADDR_W−1 → S_ERR. One slot must remain free for the sentinel.
    - N = 0 → S_TERM.
    - Otherwise → S_DATA.
  - S_DATA: collect bytes with a 2-bit byte index.
    - On the 4th byte, issue a write at address k = words_loaded, then increment words_loaded.
    - After word N−1 → S_CSUM if enabled, else S_TERM.
  - S_CSUM: compare the received byte against the running checksum.
    - Match → S_TERM.
    - Mismatch → S_ERR.
  - S_TERM: write 0xffffff00 at address N, then → S_DONE.
  - S_DONE: idle, `load_done` = 1, all further bytes ignored.
  - S_ERR: idle, `load_err` = 1, no further writes.
- Word address arithmetic is ADDR_W bits. The S_LEN bound check guarantees no wrap-around.
- Reset mid-load: return to S_LEN, clear byte index, counters and checksum, and discard any partial word. Memory already written is not cleared.

## Timing
- Reset values: `rx_ready` = 1 (S_LEN), `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0, `load_done` = 0, `load_err` = 0, `words_loaded` = 0.
- `imem_we`, `imem_addr` and `imem_wdata` are registered.
  - If the 4th byte of a word is accepted at edge t, the write is presented in the cycle after t, with `imem_we` high for exactly one cycle.
- Sentinel write: `imem_we` = 1 for the single cycle spent in S_TERM.
  - That cycle follows the last data write, or the checksum byte, or the 4th length byte when N = 0.
- `load_done` rises on the edge leaving S_TERM, i.e. one cycle after the sentinel write cycle.
- `load_err` rises on the edge that accepts the offending byte (4th length byte or checksum byte).
- Gaps in `rx_valid` stall the FSM with no state change. Back-to-back bytes are accepted every cycle.
- Throughput: one byte per cycle, so at most one memory write every 4 cycles.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - A running 8-bit XOR covers every accepted byte, length bytes included.
  - One extra checksum byte follows the data and is handled in S_CSUM.
- Not defined:
  - The S_CSUM state and checksum register are absent.
  - The byte after the last word is not consumed; the FSM goes straight to S_TERM.

## Structure
- Package `loader_pkg` holds:
  - the state enum (S_LEN, S_DATA, S_CSUM, S_TERM, S_DONE, S_ERR);
  - `END_SENTINEL` = 32'hffffff00, the single definition shared with the decoder;
  - the length-field byte count `LEN_BYTES` = 4.
- One sub-module, `word_assembler`:
  - shifts accepted bytes into a 32-bit little-endian word;
  - 2-bit index, pulses `word_valid` on the 4th byte, clears on `clr`;
  - used for both the length field and data words.

## Test plan
- N=2, words 0x00000013 and 0x00100093, no gaps → writes (0, 0x00000013), (1, 0x00100093), (2, 0xffffff00); then `load_done` = 1, `words_loaded` = 2.
- N=0 → exactly one write, (0, 0xffffff00); `load_done` = 1 one cycle later.
- N=1, word 0xdeadbeef with random 0–5 cycle `rx_valid` gaps → single write (0, 0xdeadbeef), then sentinel at address 1; no spurious `imem_we`.
- N = 2^ADDR_W (4096) → `load_err` = 1 after the 4th length byte; `imem_we` never asserted; `rx_ready` = 0.
- `LOADER_CHECKSUM_EN`, N=1, word 0x00000013, checksum byte 0x12 (correct) → sentinel written. Repeat with 0x00 → `load_err` = 1 and no sentinel write.
- Reset asserted after 2 bytes of word 0, then a full N=1 stream is sent → only the new word is written at address 0, followed by the sentinel at address 1.
